// File: rtl/nasti_write_engine.sv
// NASTI write path: expands AW bursts into per-beat commands paired with W data, one B response per burst.
// Optional macro NASTI_WRAP_BURST_EN enables WRAP decoding; otherwise WRAP is treated as a decode error.
module nasti_write_engine #(
  parameter int C_NASTI_ID_WIDTH   = 4,
  parameter int C_NASTI_ADDR_WIDTH = 32,
  parameter int C_NASTI_DATA_WIDTH = 64,
  parameter int C_NASTI_USER_WIDTH = 1,
  localparam int STRB_W     = C_NASTI_DATA_WIDTH / 8,
  localparam int AW_TRANS_W = C_NASTI_ID_WIDTH + C_NASTI_ADDR_WIDTH + 13 + C_NASTI_USER_WIDTH,
  localparam int W_TRANS_W  = C_NASTI_DATA_WIDTH + STRB_W + 1 + C_NASTI_USER_WIDTH,
  localparam int B_TRANS_W  = C_NASTI_ID_WIDTH + 2 + C_NASTI_USER_WIDTH
) (
  input  logic                          core_clk,
  input  logic                          core_rst,
  input  logic [AW_TRANS_W-1:0]         aw_rdata,
  input  logic                          aw_rempty,
  output logic                          aw_rden,
  input  logic [W_TRANS_W-1:0]          w_rdata,
  input  logic                          w_rempty,
  output logic                          w_rden,
  output logic [B_TRANS_W-1:0]          b_wdata,
  input  logic                          b_wfull,
  output logic                          b_wren,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [C_NASTI_ADDR_WIDTH-1:0] cmd_addr,
  output logic [C_NASTI_DATA_WIDTH-1:0] cmd_data,
  output logic [STRB_W-1:0]             cmd_strb,
  output logic                          cmd_last,
  output logic                          busy,
  output logic [1:0]                    state_dbg
);
  localparam int IDW      = C_NASTI_ID_WIDTH;
  localparam int ADDR_W   = C_NASTI_ADDR_WIDTH;
  localparam int UW       = C_NASTI_USER_WIDTH;
  localparam int SIZE_MAX = $clog2(STRB_W);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, RESP = 2'd2} state_t;
  state_t state_q, state_d;

  // Head-of-FIFO field layout, MSB first: {id, addr, len, size, burst, user} and {data, strb, last, user}.
  logic [IDW-1:0]    aw_id;
  logic [ADDR_W-1:0] aw_addr;
  logic [7:0]        aw_len;
  logic [2:0]        aw_size;
  logic [1:0]        aw_burst;
  logic [UW-1:0]     aw_user;
  logic [UW-1:0]     w_user;
  logic              w_last;
  logic              unused_w_user;

  assign aw_user  = aw_rdata[UW-1:0];
  assign aw_burst = aw_rdata[UW+1:UW];
  assign aw_size  = aw_rdata[UW+4:UW+2];
  assign aw_len   = aw_rdata[UW+12:UW+5];
  assign aw_addr  = aw_rdata[UW+13+ADDR_W-1:UW+13];
  assign aw_id    = aw_rdata[AW_TRANS_W-1:AW_TRANS_W-IDW];
  assign w_user   = w_rdata[UW-1:0];
  assign w_last   = w_rdata[UW];
  assign cmd_strb = w_rdata[UW+STRB_W:UW+1];
  assign cmd_data = w_rdata[W_TRANS_W-1:W_TRANS_W-C_NASTI_DATA_WIDTH];
  assign unused_w_user = ^w_user;

  logic [IDW-1:0]    id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d, beat_cnt_q, beat_cnt_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d, resp_q, resp_d;
  logic [UW-1:0]     user_q, user_d;
  logic              discard_q, discard_d;
  logic              aw_err, beat_is_last;
  logic [ADDR_W-1:0] bytes, next_addr;
`ifdef NASTI_WRAP_BURST_EN
  logic [ADDR_W-1:0] wrap_mask;
`endif

  assign beat_is_last = (beat_cnt_q == len_q);

  always_comb begin
    aw_err = 1'b0;
    if (aw_size > 3'(SIZE_MAX)) aw_err = 1'b1;
    case (aw_burst)
      2'b11: aw_err = 1'b1;
`ifdef NASTI_WRAP_BURST_EN
      2'b10: if (!(aw_len == 8'd1 || aw_len == 8'd3 || aw_len == 8'd7 || aw_len == 8'd15)) aw_err = 1'b1;
`else
      2'b10: aw_err = 1'b1;
`endif
      default: ;
    endcase
  end

  // INCR realigns after the first (possibly unaligned) beat; WRAP stays inside the mask window.
  always_comb begin
    bytes     = ONE << size_q;
    next_addr = addr_q;
`ifdef NASTI_WRAP_BURST_EN
    wrap_mask = ((ADDR_W'(len_q) + ONE) << size_q) - ONE;
`endif
    case (burst_q)
      2'b01: next_addr = (addr_q & ~(bytes - ONE)) + bytes;
`ifdef NASTI_WRAP_BURST_EN
      2'b10: next_addr = (addr_q & ~wrap_mask) | ((addr_q + bytes) & wrap_mask);
`endif
      default: ;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (aw_rden) state_d = BURST;
      BURST:   if (w_rden && beat_is_last) state_d = RESP;
      RESP:    if (b_wren) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake: a beat command transfers on a cycle with cmd_valid && cmd_ready; cmd_valid never drops
  // and cmd_addr/cmd_last never change until that transfer happens.
  always_comb begin
    aw_rden   = (state_q == IDLE) && !aw_rempty && !core_rst;
    cmd_valid = (state_q == BURST) && !discard_q && !w_rempty && !core_rst;
    cmd_last  = (state_q == BURST) && !discard_q && beat_is_last;
    w_rden    = 1'b0;
    if (state_q == BURST)
      w_rden = discard_q ? (!w_rempty && !core_rst) : (cmd_valid && cmd_ready);
    b_wren    = (state_q == RESP) && !b_wfull && !core_rst;
    busy      = (state_q != IDLE);
  end

  always_comb begin
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    user_d     = user_q;
    beat_cnt_d = beat_cnt_q;
    resp_d     = resp_q;
    discard_d  = discard_q;
    if (aw_rden) begin
      id_d       = aw_id;
      addr_d     = aw_addr;
      len_d      = aw_len;
      size_d     = aw_size;
      burst_d    = aw_burst;
      user_d     = aw_user;
      beat_cnt_d = 8'd0;
      resp_d     = aw_err ? RESP_SLVERR : RESP_OKAY;
      discard_d  = aw_err;
    end else if (w_rden) begin
      beat_cnt_d = beat_cnt_q + 8'd1;
      addr_d     = next_addr;
      if (w_last != beat_is_last) resp_d = RESP_SLVERR;
    end
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      user_q     <= '0;
      beat_cnt_q <= '0;
      resp_q     <= RESP_OKAY;
      discard_q  <= 1'b0;
    end else begin
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      user_q     <= user_d;
      beat_cnt_q <= beat_cnt_d;
      resp_q     <= resp_d;
      discard_q  <= discard_d;
    end
  end

  assign cmd_addr  = addr_q;
  assign b_wdata   = {id_q, resp_q, user_q};
  assign state_dbg = state_q;
endmodule

// File: tb/tb_nasti_write_engine.sv
// Directed bench for nasti_write_engine: FWFT FIFO models around the DUT, per-scenario tasks with inline checks.
module tb_nasti_write_engine;
  localparam int IDW = 4, AW = 32, DW = 64, UW = 2, SW = 8;
  localparam int AWT = IDW + AW + 13 + UW;
  localparam int WT  = DW + SW + 1 + UW;
  localparam int BT  = IDW + 2 + UW;

  logic           core_clk = 1'b0;
  logic           core_rst = 1'b1;
  logic [AWT-1:0] aw_rdata = '0;
  logic           aw_rempty = 1'b1;
  logic           aw_rden;
  logic [WT-1:0]  w_rdata = '0;
  logic           w_rempty = 1'b1;
  logic           w_rden;
  logic [BT-1:0]  b_wdata;
  logic           b_wfull = 1'b0;
  logic           b_wren;
  logic           cmd_valid;
  logic           cmd_ready = 1'b1;
  logic [AW-1:0]  cmd_addr;
  logic [DW-1:0]  cmd_data;
  logic [SW-1:0]  cmd_strb;
  logic           cmd_last;
  logic           busy;
  logic [1:0]     state_dbg;

  nasti_write_engine #(.C_NASTI_ID_WIDTH(IDW), .C_NASTI_ADDR_WIDTH(AW),
                       .C_NASTI_DATA_WIDTH(DW), .C_NASTI_USER_WIDTH(UW)) dut (
    .core_clk(core_clk), .core_rst(core_rst),
    .aw_rdata(aw_rdata), .aw_rempty(aw_rempty), .aw_rden(aw_rden),
    .w_rdata(w_rdata), .w_rempty(w_rempty), .w_rden(w_rden),
    .b_wdata(b_wdata), .b_wfull(b_wfull), .b_wren(b_wren),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_strb(cmd_strb), .cmd_last(cmd_last),
    .busy(busy), .state_dbg(state_dbg)
  );

  always #5 core_clk = ~core_clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [AWT-1:0] aw_fifo[$];
  logic [WT-1:0]  w_fifo[$];
  logic [AW-1:0]  exp_q[$];
  logic [AW-1:0]  obs_addr[$];
  logic           obs_last[$];
  logic [DW-1:0]  obs_data[$];
  logic [BT-1:0]  obs_b[$];
  int cmd_cyc[$], b_cyc[$], aw_cyc[$];
  int w_pops, unfired_pops, stall_viol, stalls;

  // FIFO models and monitor: sample on the falling edge, apply pops just after the rising edge.
  always begin : fifo_model
    logic s_aw, s_w, s_fire, s_last, s_b, prev_stall;
    logic [AW-1:0] s_addr, prev_addr;
    logic [DW-1:0] s_data;
    logic [BT-1:0] s_bd;
    logic prev_last;
    prev_stall = 1'b0; prev_addr = '0; prev_last = 1'b0;
    forever begin
      @(negedge core_clk);
      s_aw = aw_rden; s_w = w_rden; s_fire = cmd_valid && cmd_ready;
      s_addr = cmd_addr; s_last = cmd_last; s_data = cmd_data;
      s_b = b_wren; s_bd = b_wdata;
      if (prev_stall && (!cmd_valid || cmd_addr !== prev_addr || cmd_last !== prev_last)) stall_viol++;
      prev_stall = cmd_valid && !cmd_ready;
      if (prev_stall) stalls++;
      prev_addr = cmd_addr; prev_last = cmd_last;
      @(posedge core_clk); #1;
      if (s_aw) begin
        aw_cyc.push_back(cyc);
        if (aw_fifo.size() > 0) void'(aw_fifo.pop_front());
      end
      if (s_w) begin
        w_pops++;
        if (!s_fire) unfired_pops++;
        if (w_fifo.size() > 0) void'(w_fifo.pop_front());
      end
      if (s_fire) begin
        obs_addr.push_back(s_addr); obs_last.push_back(s_last);
        obs_data.push_back(s_data); cmd_cyc.push_back(cyc);
      end
      if (s_b) begin
        obs_b.push_back(s_bd); b_cyc.push_back(cyc);
      end
      cyc++;
      aw_rempty = (aw_fifo.size() == 0);
      aw_rdata  = aw_rempty ? '0 : aw_fifo[0];
      w_rempty  = (w_fifo.size() == 0);
      w_rdata   = w_rempty ? '0 : w_fifo[0];
    end
  end

  function automatic logic [AWT-1:0] mk_aw(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst, input logic [UW-1:0] user);
    return {id, addr, len, size, burst, user};
  endfunction

  function automatic logic [WT-1:0] mk_w(input logic [DW-1:0] data, input logic [SW-1:0] strb, input logic last);
    return {data, strb, last, 2'b00};
  endfunction

  task automatic tick();
    @(posedge core_clk); #2;
  endtask

  task automatic clear_obs();
    obs_addr.delete(); obs_last.delete(); obs_data.delete(); obs_b.delete(); exp_q.delete();
    cmd_cyc.delete(); b_cyc.delete(); aw_cyc.delete();
    w_pops = 0; unfired_pops = 0; stall_viol = 0; stalls = 0;
  endtask

  task automatic push_beats(input int n, input logic [DW-1:0] base, input int last_idx);
    for (int i = 0; i < n; i++) w_fifo.push_back(mk_w(base + DW'(i), 8'hFF, i == last_idx));
  endtask

  task automatic wait_b(input int n, input string name);
    int k = 0;
    while (obs_b.size() < n && k < 300) begin tick(); k++; end
    checks++;
    if (obs_b.size() < n) begin
      errors++; $display("FAIL %s_timeout: b pushes %0d, required %0d", name, obs_b.size(), n);
    end
  endtask

  task automatic test_reset();
    core_rst = 1'b1;
    repeat (3) tick();
    @(negedge core_clk);
    checks++; if (aw_rden !== 1'b0)   begin errors++; $display("FAIL rst_aw_rden: got %b want 0", aw_rden); end
    checks++; if (w_rden !== 1'b0)    begin errors++; $display("FAIL rst_w_rden: got %b want 0", w_rden); end
    checks++; if (b_wren !== 1'b0)    begin errors++; $display("FAIL rst_b_wren: got %b want 0", b_wren); end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_cmd_valid: got %b want 0", cmd_valid); end
    checks++; if (cmd_last !== 1'b0)  begin errors++; $display("FAIL rst_cmd_last: got %b want 0", cmd_last); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (b_wdata !== '0)     begin errors++; $display("FAIL rst_b_wdata: got %h want 0", b_wdata); end
    checks++; if (cmd_addr !== '0)    begin errors++; $display("FAIL rst_cmd_addr: got %h want 0", cmd_addr); end
    tick();
    core_rst = 1'b0;
    tick();
  endtask

  task automatic test_single_beat();
    clear_obs(); cmd_ready = 1'b1;
    push_beats(2, 64'h11, 0);
    w_fifo[1] = mk_w(64'h12, 8'hFF, 1'b1);
    aw_fifo.push_back(mk_aw(4'd1, 32'h10, 8'd0, 3'd3, 2'b01, 2'd2));
    aw_fifo.push_back(mk_aw(4'd2, 32'h20, 8'd0, 3'd3, 2'b01, 2'd0));
    wait_b(2, "single");
    if (obs_b.size() == 2 && aw_cyc.size() == 2 && cmd_cyc.size() == 2) begin
      checks++; if (cmd_cyc[0] !== aw_cyc[0] + 1) begin errors++; $display("FAIL single_cmd_lat: got %0d want %0d", cmd_cyc[0], aw_cyc[0] + 1); end
      checks++; if (b_cyc[0] !== aw_cyc[0] + 2)   begin errors++; $display("FAIL single_b_lat: got %0d want %0d", b_cyc[0], aw_cyc[0] + 2); end
      checks++; if (aw_cyc[1] !== aw_cyc[0] + 3)  begin errors++; $display("FAIL single_next_aw: got %0d want %0d", aw_cyc[1], aw_cyc[0] + 3); end
      checks++; if (obs_b[0] !== {4'd1, 2'b00, 2'd2}) begin errors++; $display("FAIL single_b0: got %h want %h", obs_b[0], {4'd1, 2'b00, 2'd2}); end
      checks++; if (obs_addr[1] !== 32'h20) begin errors++; $display("FAIL single_addr1: got %h want 20", obs_addr[1]); end
    end
    repeat (2) tick();
  endtask

  task automatic test_incr();
    logic [3:0] lasts;
    clear_obs(); cmd_ready = 1'b1;
    push_beats(4, 64'hA0, 3);
    aw_fifo.push_back(mk_aw(4'd5, 32'h100, 8'd3, 3'd3, 2'b01, 2'd1));
    exp_q = '{32'h100, 32'h108, 32'h110, 32'h118};
    wait_b(1, "incr");
    checks++; if (obs_addr.size() !== 4) begin errors++; $display("FAIL incr_count: got %0d want 4", obs_addr.size()); end
    if (obs_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (obs_addr[i] !== exp_q[i]) begin errors++; $display("FAIL incr_addr%0d: got %h want %h", i, obs_addr[i], exp_q[i]); end
      end
      lasts = {obs_last[3], obs_last[2], obs_last[1], obs_last[0]};
      checks++; if (lasts !== 4'b1000) begin errors++; $display("FAIL incr_last: got %b want 1000", lasts); end
      checks++; if (obs_data[2] !== 64'hA2) begin errors++; $display("FAIL incr_data2: got %h want a2", obs_data[2]); end
      checks++; if (cmd_cyc[3] !== cmd_cyc[0] + 3) begin errors++; $display("FAIL incr_rate: got %0d want %0d", cmd_cyc[3], cmd_cyc[0] + 3); end
    end
    if (obs_b.size() > 0) begin
      checks++; if (obs_b[0] !== {4'd5, 2'b00, 2'd1}) begin errors++; $display("FAIL incr_b: got %h want %h", obs_b[0], {4'd5, 2'b00, 2'd1}); end
    end
    repeat (2) tick();
  endtask

  task automatic test_wrap();
    clear_obs(); cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) w_fifo.push_back(mk_w(64'hC0 + DW'(i), 8'h0F, i == 3));
    aw_fifo.push_back(mk_aw(4'd3, 32'h38, 8'd3, 3'd2, 2'b10, 2'd0));
    wait_b(1, "wrap");
`ifdef NASTI_WRAP_BURST_EN
    exp_q = '{32'h38, 32'h3C, 32'h30, 32'h34};
    checks++; if (obs_addr.size() !== 4) begin errors++; $display("FAIL wrap_count: got %0d want 4", obs_addr.size()); end
    if (obs_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (obs_addr[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_addr%0d: got %h want %h", i, obs_addr[i], exp_q[i]); end
      end
    end
    if (obs_b.size() > 0) begin
      checks++; if (obs_b[0] !== {4'd3, 2'b00, 2'd0}) begin errors++; $display("FAIL wrap_b: got %h want %h", obs_b[0], {4'd3, 2'b00, 2'd0}); end
    end
`else
    checks++; if (obs_addr.size() !== 0) begin errors++; $display("FAIL wrap_off_cmds: got %0d want 0", obs_addr.size()); end
    checks++; if (w_pops !== 4) begin errors++; $display("FAIL wrap_off_pops: got %0d want 4", w_pops); end
    if (obs_b.size() > 0) begin
      checks++; if (obs_b[0] !== {4'd3, 2'b10, 2'd0}) begin errors++; $display("FAIL wrap_off_b: got %h want %h", obs_b[0], {4'd3, 2'b10, 2'd0}); end
    end
`endif
    repeat (2) tick();
  endtask

  task automatic test_fixed_stall();
    logic [2:0] lasts;
    clear_obs(); cmd_ready = 1'b0;
    push_beats(3, 64'hF0, 2);
    aw_fifo.push_back(mk_aw(4'd6, 32'h40, 8'd2, 3'd3, 2'b00, 2'd3));
    for (int k = 0; k < 100 && obs_b.size() == 0; k++) begin cmd_ready = ~cmd_ready; tick(); end
    cmd_ready = 1'b1;
    wait_b(1, "fixed");
    checks++; if (obs_addr.size() !== 3) begin errors++; $display("FAIL fixed_count: got %0d want 3", obs_addr.size()); end
    if (obs_addr.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (obs_addr[i] !== 32'h40) begin errors++; $display("FAIL fixed_addr%0d: got %h want 40", i, obs_addr[i]); end
      end
      lasts = {obs_last[2], obs_last[1], obs_last[0]};
      checks++; if (lasts !== 3'b100) begin errors++; $display("FAIL fixed_last: got %b want 100", lasts); end
    end
    checks++; if (stalls == 0) begin errors++; $display("FAIL fixed_stall_seen: got %0d stalled cycles, want >0", stalls); end
    checks++; if (stall_viol !== 0) begin errors++; $display("FAIL fixed_stable: got %0d changes while stalled, want 0", stall_viol); end
    checks++; if (unfired_pops !== 0 || w_pops !== 3) begin errors++; $display("FAIL fixed_wpops: got %0d pops (%0d unaccepted), want 3 (0)", w_pops, unfired_pops); end
    if (obs_b.size() > 0) begin
      checks++; if (obs_b[0] !== {4'd6, 2'b00, 2'd3}) begin errors++; $display("FAIL fixed_b: got %h want %h", obs_b[0], {4'd6, 2'b00, 2'd3}); end
    end
    repeat (2) tick();
  endtask

  task automatic test_errors();
    clear_obs(); cmd_ready = 1'b1;
    push_beats(4, 64'h70, 1);
    aw_fifo.push_back(mk_aw(4'd7, 32'h0, 8'd3, 3'd3, 2'b01, 2'd0));
    wait_b(1, "wlast");
    checks++; if (obs_addr.size() !== 4) begin errors++; $display("FAIL wlast_count: got %0d want 4", obs_addr.size()); end
    if (obs_b.size() > 0) begin
      checks++; if (obs_b[0] !== {4'd7, 2'b10, 2'd0}) begin errors++; $display("FAIL wlast_b: got %h want %h", obs_b[0], {4'd7, 2'b10, 2'd0}); end
    end
    repeat (2) tick();
    clear_obs();
    push_beats(2, 64'h80, 1);
    aw_fifo.push_back(mk_aw(4'd8, 32'h80, 8'd1, 3'd4, 2'b01, 2'd0));
    wait_b(1, "size");
    checks++; if (obs_addr.size() !== 0) begin errors++; $display("FAIL size_cmds: got %0d want 0", obs_addr.size()); end
    checks++; if (unfired_pops !== 2) begin errors++; $display("FAIL size_drain: got %0d want 2", unfired_pops); end
    if (obs_b.size() > 0) begin
      checks++; if (obs_b[0] !== {4'd8, 2'b10, 2'd0}) begin errors++; $display("FAIL size_b: got %h want %h", obs_b[0], {4'd8, 2'b10, 2'd0}); end
    end
    repeat (2) tick();
    clear_obs();
    push_beats(1, 64'h90, 0);
    aw_fifo.push_back(mk_aw(4'd9, 32'h90, 8'd0, 3'd3, 2'b11, 2'd0));
    wait_b(1, "burst3");
    checks++; if (obs_addr.size() !== 0 || w_pops !== 1) begin errors++; $display("FAIL burst3_drain: got %0d cmds %0d pops want 0 1", obs_addr.size(), w_pops); end
    if (obs_b.size() > 0) begin
      checks++; if (obs_b[0] !== {4'd9, 2'b10, 2'd0}) begin errors++; $display("FAIL burst3_b: got %h want %h", obs_b[0], {4'd9, 2'b10, 2'd0}); end
    end
    repeat (2) tick();
  endtask

  task automatic test_bfull();
    int k, rel_cyc;
    clear_obs(); cmd_ready = 1'b1; b_wfull = 1'b1;
    push_beats(2, 64'h50, 0);
    w_fifo[1] = mk_w(64'h51, 8'hFF, 1'b1);
    aw_fifo.push_back(mk_aw(4'd10, 32'h500, 8'd0, 3'd3, 2'b01, 2'd0));
    aw_fifo.push_back(mk_aw(4'd11, 32'h600, 8'd0, 3'd3, 2'b01, 2'd0));
    k = 0;
    while (obs_addr.size() < 1 && k < 100) begin tick(); k++; end
    repeat (10) tick();
    checks++; if (obs_b.size() !== 0) begin errors++; $display("FAIL bfull_push: got %0d pushes want 0", obs_b.size()); end
    checks++; if (aw_cyc.size() !== 1) begin errors++; $display("FAIL bfull_aw: got %0d pops want 1", aw_cyc.size()); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bfull_busy: got %b want 1", busy); end
    rel_cyc = cyc;
    b_wfull = 1'b0;
    wait_b(2, "bfull");
    if (obs_b.size() == 2 && aw_cyc.size() == 2) begin
      checks++; if (b_cyc[0] !== rel_cyc) begin errors++; $display("FAIL bfull_release: got %0d want %0d", b_cyc[0], rel_cyc); end
      checks++; if (aw_cyc[1] !== b_cyc[0] + 1) begin errors++; $display("FAIL bfull_next_aw: got %0d want %0d", aw_cyc[1], b_cyc[0] + 1); end
      checks++; if (obs_b[0] !== {4'd10, 2'b00, 2'd0}) begin errors++; $display("FAIL bfull_b0: got %h want %h", obs_b[0], {4'd10, 2'b00, 2'd0}); end
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    int k;
    clear_obs(); cmd_ready = 1'b1;
    push_beats(8, 64'h200, 7);
    aw_fifo.push_back(mk_aw(4'd12, 32'h200, 8'd7, 3'd3, 2'b01, 2'd0));
    k = 0;
    while (obs_addr.size() < 1 && k < 100) begin tick(); k++; end
    core_rst = 1'b1;
    tick();
    @(negedge core_clk);
    checks++; if (busy !== 1'b0 || cmd_valid !== 1'b0) begin errors++; $display("FAIL rmid_idle: got busy %b valid %b want 0 0", busy, cmd_valid); end
    checks++; if (cmd_addr !== '0 || b_wdata !== '0) begin errors++; $display("FAIL rmid_outs: got addr %h b %h want 0 0", cmd_addr, b_wdata); end
    checks++; if (w_rden !== 1'b0 || b_wren !== 1'b0) begin errors++; $display("FAIL rmid_strobes: got w %b b %b want 0 0", w_rden, b_wren); end
    tick();
    core_rst = 1'b0;
    repeat (5) tick();
    checks++; if (obs_b.size() !== 0) begin errors++; $display("FAIL rmid_nob: got %0d pushes want 0", obs_b.size()); end
    checks++; if (w_pops !== 1 || obs_addr.size() !== 1) begin errors++; $display("FAIL rmid_beats: got %0d pops %0d cmds want 1 1", w_pops, obs_addr.size()); end
    w_fifo.delete();
    clear_obs();
    push_beats(2, 64'h300, 1);
    aw_fifo.push_back(mk_aw(4'd13, 32'h300, 8'd1, 3'd3, 2'b01, 2'd1));
    wait_b(1, "rmid_next");
    checks++; if (obs_addr.size() !== 2) begin errors++; $display("FAIL rmid_count: got %0d want 2", obs_addr.size()); end
    if (obs_addr.size() == 2) begin
      checks++; if (obs_addr[1] !== 32'h308) begin errors++; $display("FAIL rmid_addr1: got %h want 308", obs_addr[1]); end
    end
    if (obs_b.size() > 0) begin
      checks++; if (obs_b[0] !== {4'd13, 2'b00, 2'd1}) begin errors++; $display("FAIL rmid_b: got %h want %h", obs_b[0], {4'd13, 2'b00, 2'd1}); end
    end
    repeat (2) tick();
  endtask

  initial begin
    clear_obs();
    test_reset();
    test_single_beat();
    test_incr();
    test_wrap();
    test_fixed_stall();
    test_errors();
    test_bfull();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
